// File: rtl/vga_timing_pkg.sv
// XVGA raster constants and pixel/sync payload types shared by the display
// timing source and every sprite block on the hcount/vcount bus.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 1024;
    localparam int unsigned H_FP     = 24;
    localparam int unsigned H_SYNC   = 136;
    localparam int unsigned H_BP     = 160;
    localparam int unsigned V_ACTIVE = 768;
    localparam int unsigned V_FP     = 3;
    localparam int unsigned V_SYNC   = 6;
    localparam int unsigned V_BP     = 29;

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int unsigned HCOUNT_W = 11;
    localparam int unsigned VCOUNT_W = 10;
    localparam int unsigned COLOR_W  = 8;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } pixel_t;

    // Raw (active-high) timing flags carried alongside the sprite pipeline.
    typedef struct packed {
        logic blank;
        logic hsync;
        logic vsync;
    } sync_t;

endpackage

// File: rtl/sync_delay_line.sv
// Resettable shift register that holds timing flags back to meet the
// returning pixel; DEPTH of zero collapses to a straight wire.
module sync_delay_line #(
    parameter int unsigned       WIDTH     = 3,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d[0] = din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RESET_VAL;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/display_timing.sv
// Raster counter source for the sprite bus: generates hcount/vcount/blank,
// realigns syncs with the returned pixel and registers everything to the pins.
module display_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned PIX_LATENCY = 2,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned H_ACT       = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FRONT     = vga_timing_pkg::H_FP,
    parameter int unsigned H_PULSE     = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK      = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACT       = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FRONT     = vga_timing_pkg::V_FP,
    parameter int unsigned V_PULSE     = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK      = vga_timing_pkg::V_BP
) (
    input  logic                pixel_clk,
    input  logic                reset,
    output logic [HCOUNT_W-1:0] hcount,
    output logic [VCOUNT_W-1:0] vcount,
    output logic                blank,
    output logic                frame_start,
    input  pixel_t              pixel_in,
    output logic [COLOR_W-1:0]  vga_r,
    output logic [COLOR_W-1:0]  vga_g,
    output logic [COLOR_W-1:0]  vga_b,
    output logic                vga_hsync,
    output logic                vga_vsync
);

    localparam int unsigned H_TOT    = H_ACT + H_FRONT + H_PULSE + H_BACK;
    localparam int unsigned V_TOT    = V_ACT + V_FRONT + V_PULSE + V_BACK;
    localparam int unsigned HS_START = H_ACT + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_PULSE;
    localparam int unsigned VS_START = V_ACT + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_PULSE;

    localparam sync_t DLY_RESET = '{blank: 1'b1, hsync: 1'b0, vsync: 1'b0};

    logic [HCOUNT_W-1:0] hcount_q, hcount_d;
    logic [VCOUNT_W-1:0] vcount_q, vcount_d;
    logic                blank_q, blank_d;
    logic                frame_start_q, frame_start_d;
    pixel_t              rgb_q, rgb_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                h_wrap, v_wrap;
    sync_t               raw_sync;
    sync_t               dly_sync;

    // Counters advance every clock; blank is decoded from the next counts so
    // that it lands in the same cycle as the counts it describes.
    always_comb begin
        h_wrap        = (hcount_q == HCOUNT_W'(H_TOT - 1));
        v_wrap        = (vcount_q == VCOUNT_W'(V_TOT - 1));
        hcount_d      = h_wrap ? '0 : hcount_q + HCOUNT_W'(1);
        vcount_d      = vcount_q;
        if (h_wrap) begin
            vcount_d = v_wrap ? '0 : vcount_q + VCOUNT_W'(1);
        end
        blank_d       = (hcount_d >= HCOUNT_W'(H_ACT)) || (vcount_d >= VCOUNT_W'(V_ACT));
        frame_start_d = h_wrap && v_wrap;
    end

    always_comb begin
        raw_sync.blank = blank_q;
        raw_sync.hsync = (hcount_q >= HCOUNT_W'(HS_START)) && (hcount_q < HCOUNT_W'(HS_END));
        raw_sync.vsync = (vcount_q >= VCOUNT_W'(VS_START)) && (vcount_q < VCOUNT_W'(VS_END));
    end

    sync_delay_line #(
        .WIDTH     ($bits(sync_t)),
        .DEPTH     (PIX_LATENCY),
        .RESET_VAL (DLY_RESET)
    ) u_sync_delay (
        .clk   (pixel_clk),
        .reset (reset),
        .din   (raw_sync),
        .dout  (dly_sync)
    );

    // Pin stage: blanked pixels are forced black so nothing undefined reaches the DAC.
    always_comb begin
        rgb_d   = dly_sync.blank ? '0 : pixel_in;
        hsync_d = dly_sync.hsync ? SYNC_POL : ~SYNC_POL;
        vsync_d = dly_sync.vsync ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            blank_q       <= 1'b0;
            frame_start_q <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;
    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;

endmodule
